// File: rtl/sdpram_burst_ctrl.sv
// Burst controller sequencing the 32x256 dual-port row RAM: write bursts
// stream rows into port A, read bursts stream rows out of port B through a
// 2-entry output FIFO. One command at a time, done pulse per command.
module sdpram_burst_ctrl #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned LEN_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] ram_d_a,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic              ram_wen_a,
    output logic [DATA_W-1:0] ram_d_b,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic              ram_wen_b,
    input  logic [DATA_W-1:0] ram_q_b
);

    localparam int unsigned     DEPTH   = 2 ** ADDR_W;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_FINISH
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [ADDR_W-1:0]  base_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;       // rows written (write) or reads issued (read)
    logic [LEN_W-1:0]   pop_cnt_q;   // rows delivered on the read stream
    logic               inflight_q;  // a RAM read is returning this cycle
    logic [1:0]         fifo_cnt_q;
    logic [1:0]         fifo_cnt_d;
    logic [DATA_W-1:0]  fifo0_q;     // FIFO head
    logic [DATA_W-1:0]  fifo1_q;

    logic               cmd_fire;
    logic               wr_beat;
    logic               pop;
    logic               issue;
    logic [LEN_W-1:0]   len_sat;
    logic [2:0]         occ;

    // Port B never writes; its address walks the issue counter
    assign ram_d_b    = '0;
    assign ram_wen_b  = 1'b0;
    assign ram_addr_b = base_q + ADDR_W'(cnt_q);
    assign out_data   = fifo0_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshakes and read-issue decision
    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        cmd_fire   = cmd_valid & cmd_ready;
        wr_beat    = in_valid & in_ready;
        pop        = out_valid & out_ready;
        len_sat    = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
        // Occupancy after this cycle's pop: entries held plus the row in flight
        occ        = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(pop);
        fifo_cnt_d = 2'(fifo_cnt_q + 2'(inflight_q) - 2'(pop));
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    if (len_sat == '0) begin
                        state_d = S_FINISH;
                    end else if (cmd_write) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (wr_beat && (cnt_q + LEN_W'(1) == len_q)) begin
                    state_d = S_FINISH;
                end
            end
            S_READ: begin
                issue = (cnt_q < len_q) && (occ < 3'd2);
                if (pop && (pop_cnt_q + LEN_W'(1) == len_q)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Command latch and burst counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            pop_cnt_q <= '0;
        end else if (cmd_fire) begin
            base_q    <= cmd_addr;
            len_q     <= len_sat;
            cnt_q     <= '0;
            pop_cnt_q <= '0;
        end else begin
            if (wr_beat || issue) begin
                cnt_q <= cnt_q + LEN_W'(1);
            end
            if (pop) begin
                pop_cnt_q <= pop_cnt_q + LEN_W'(1);
            end
        end
    end

    // Port A write register: one-cycle enable per accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_wen_a  <= 1'b0;
            ram_addr_a <= '0;
            ram_d_a    <= '0;
        end else begin
            ram_wen_a <= wr_beat;
            if (wr_beat) begin
                ram_addr_a <= base_q + ADDR_W'(cnt_q);
                ram_d_a    <= in_data;
            end
        end
    end

    // Output FIFO: push returning RAM row, pop on read-stream handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            fifo_cnt_q <= '0;
            fifo0_q    <= '0;
            fifo1_q    <= '0;
            out_valid  <= 1'b0;
        end else begin
            inflight_q <= issue;
            fifo_cnt_q <= fifo_cnt_d;
            out_valid  <= (fifo_cnt_d != 2'd0);
            case ({inflight_q, pop})
                2'b10: begin
                    if (fifo_cnt_q == 2'd0) begin
                        fifo0_q <= ram_q_b;
                    end else begin
                        fifo1_q <= ram_q_b;
                    end
                end
                2'b01: begin
                    fifo0_q <= fifo1_q;
                end
                2'b11: begin
                    if (fifo_cnt_q == 2'd1) begin
                        fifo0_q <= ram_q_b;
                    end else begin
                        fifo0_q <= fifo1_q;
                        fifo1_q <= ram_q_b;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered status outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready <= 1'b1;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cmd_ready <= (state_d == S_IDLE);
            in_ready  <= (state_d == S_WRITE);
            busy      <= (state_d != S_IDLE);
            done      <= (state_d == S_FINISH);
        end
    end

endmodule

// File: tb/tb_sdpram_burst_ctrl.sv
// Bench for sdpram_burst_ctrl: RAM model, queue-based behavioural model with
// per-cycle compare, and directed bursts with hand-computed expectations.
module tb_sdpram_burst_ctrl;

    localparam int unsigned DW = 256;
    localparam int unsigned AW = 5;
    localparam int unsigned LW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] in_data;
    logic          in_valid, in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready;
    logic          busy, done;
    logic [DW-1:0] ram_d_a, ram_d_b, ram_q_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic          ram_wen_a, ram_wen_b;

    sdpram_burst_ctrl #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done),
        .ram_d_a(ram_d_a), .ram_addr_a(ram_addr_a), .ram_wen_a(ram_wen_a),
        .ram_d_b(ram_d_b), .ram_addr_b(ram_addr_b), .ram_wen_b(ram_wen_b),
        .ram_q_b(ram_q_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous dual-port RAM with registered port-B read
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        if (ram_wen_a) mem[ram_addr_a] <= ram_d_a;
        ram_q_b <= mem[ram_addr_b];
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0b expected %0b", name, act, exp);
    endtask

    // Behavioural model state
    logic [DW-1:0] gold [32];
    logic [DW-1:0] m_rd_q [$];
    logic          m_busy = 1'b0, m_done_now = 1'b0, m_rd = 1'b0, first_seen = 1'b0;
    int            m_wr_left = 0, m_len = 0, m_popped = 0, m_hs = 0;
    logic [AW-1:0] m_base = '0, m_wr_addr = '0;
    logic          exp_wen = 1'b0;
    logic [AW-1:0] exp_waddr = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;

    // Per-cycle compare against the model, then advance the model
    always @(negedge clk) begin : compare
        logic          fin_next;
        logic [AW-1:0] issued;
        logic [AW-1:0] a;
        if (!rst_n) begin
            chk1("rst_cmd_ready", cmd_ready, 1'b1);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_done", done, 1'b0);
            chk1("rst_in_ready", in_ready, 1'b0);
            chk1("rst_out_valid", out_valid, 1'b0);
            chk1("rst_wen_a", ram_wen_a, 1'b0);
            chk("rst_addr_a", DW'(ram_addr_a), '0);
            chk("rst_d_a", ram_d_a, '0);
            chk("rst_addr_b", DW'(ram_addr_b), '0);
            m_busy = 1'b0; m_done_now = 1'b0; m_rd = 1'b0; m_wr_left = 0;
            exp_wen = 1'b0; hold_v = 1'b0; m_rd_q.delete();
        end else begin
            chk1("busy", busy, m_busy);
            chk1("cmd_ready", cmd_ready, !m_busy);
            chk1("done", done, m_done_now);
            chk1("in_ready", in_ready, m_wr_left > 0);
            chk1("ram_wen_a", ram_wen_a, exp_wen);
            if (exp_wen) begin
                chk("ram_addr_a", DW'(ram_addr_a), DW'(exp_waddr));
                chk("ram_d_a", ram_d_a, exp_wdata);
            end
            chk1("ram_wen_b", ram_wen_b, 1'b0);
            chk("ram_d_b", ram_d_b, '0);
            if (hold_v) begin
                chk1("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, hold_d);
            end
            if (!m_rd) begin
                chk1("out_valid_idle", out_valid, 1'b0);
            end else begin
                // Outstanding reads (FIFO + in flight) never exceed two rows
                issued = ram_addr_b - m_base;
                chk1("issue_bound", (32'(issued) <= m_popped + 2) && (32'(issued) <= m_len), 1'b1);
                // Handshake edge is one edge after this sample; data two edges later
                if (out_valid && !first_seen) begin
                    first_seen = 1'b1;
                    chk("first_valid_lat", DW'(cyc - m_hs), DW'(3));
                end
            end

            fin_next = 1'b0;
            exp_wen  = 1'b0;
            if (m_wr_left > 0 && in_valid && in_ready) begin
                exp_wen   = 1'b1;
                exp_waddr = m_wr_addr;
                exp_wdata = in_data;
                gold[m_wr_addr] = in_data;
                m_wr_addr = m_wr_addr + 1'b1;
                m_wr_left--;
                if (m_wr_left == 0) fin_next = 1'b1;
            end
            hold_v = m_rd && out_valid && !out_ready;
            hold_d = out_data;
            if (m_rd && out_valid && out_ready) begin
                if (m_rd_q.size() > 0) chk("out_data", out_data, m_rd_q.pop_front());
                m_popped++;
                if (m_popped == m_len) begin
                    m_rd = 1'b0;
                    fin_next = 1'b1;
                end
            end
            if (m_done_now) begin
                m_busy = 1'b0;
            end else if (!m_busy && cmd_valid) begin
                m_busy = 1'b1;
                m_base = cmd_addr;
                m_len  = (int'(cmd_len) > 32) ? 32 : int'(cmd_len);
                m_hs   = cyc;
                if (m_len == 0) begin
                    fin_next = 1'b1;
                end else if (cmd_write) begin
                    m_wr_left = m_len;
                    m_wr_addr = cmd_addr;
                end else begin
                    m_rd = 1'b1;
                    m_popped = 0;
                    first_seen = 1'b0;
                    m_rd_q.delete();
                    a = cmd_addr;
                    for (int i = 0; i < m_len; i++) begin
                        m_rd_q.push_back(gold[a]);
                        a = a + 1'b1;
                    end
                end
            end
            m_done_now = fin_next;
        end
    end

    // Event logs for the directed literal checks
    int            done_cnt = 0;
    int            ov_cnt = 0;
    logic [AW-1:0] waddr_log [$];
    logic [DW-1:0] wdata_log [$];
    logic [DW-1:0] rlog [$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (out_valid) ov_cnt++;
            if (ram_wen_a) begin
                waddr_log.push_back(ram_addr_a);
                wdata_log.push_back(ram_d_a);
            end
            if (out_valid && out_ready) rlog.push_back(out_data);
        end
    end

    logic [DW-1:0] wq [$];
    bit            rpat [$];

    task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] l, input int hold);
        int k = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        while (!cmd_ready && k < 50) begin @(posedge clk); #1; k++; end
        if (k >= 50) chk1("cmd_ready_wait", cmd_ready, 1'b1);
        repeat (1 + hold) begin @(posedge clk); #1; end
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] l, input int n);
        int k;
        int d0 = done_cnt;
        waddr_log.delete(); wdata_log.delete();
        send_cmd(1'b1, a, l, 0);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = wq[i];
            k = 0;
            while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
            if (k >= 50) chk1("in_ready_wait", in_ready, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 50) begin @(posedge clk); #1; k++; end
        chk("wr_done_count", DW'(done_cnt - d0), DW'(1));
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] l, input int abort_after);
        int k = 0;
        int d0 = done_cnt;
        rlog.delete();
        out_ready = rpat[0];
        send_cmd(1'b0, a, l, 0);
        while (done_cnt == d0 && k < 200) begin
            if (abort_after != 0 && rlog.size() >= abort_after) break;
            out_ready = rpat[k % rpat.size()];
            @(posedge clk); #1;
            k++;
        end
        out_ready = 1'b1;
        if (abort_after == 0) begin
            chk("rd_done_count", DW'(done_cnt - d0), DW'(1));
            repeat (2) begin @(posedge clk); #1; end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        int d0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk1("init_cmd_ready", cmd_ready, 1'b1);
        chk1("init_busy", busy, 1'b0);
        chk1("init_out_valid", out_valid, 1'b0);
        chk1("init_wen_a", ram_wen_a, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Length 40 saturates to a full 32-row write from row 0
        wq.delete();
        for (int i = 0; i < 32; i++) wq.push_back(DW'(32'hC000 + i));
        do_write(5'd0, 6'd40, 32);
        chk("sat_beats", DW'(waddr_log.size()), DW'(32));
        chk("sat_last_addr", DW'(waddr_log[31]), DW'(31));
        chk("sat_last_data", wdata_log[31], DW'(32'hC01F));

        // Write base 1, two rows
        wq = '{DW'(1337), DW'(2022)};
        do_write(5'd1, 6'd2, 2);
        chk("w1_beats", DW'(waddr_log.size()), DW'(2));
        chk("w1_addr0", DW'(waddr_log[0]), DW'(1));
        chk("w1_addr1", DW'(waddr_log[1]), DW'(2));
        chk("w1_data0", wdata_log[0], DW'(1337));
        chk("w1_data1", wdata_log[1], DW'(2022));
        chk1("w1_busy_after", busy, 1'b0);

        // Read it back at full rate
        rpat = '{1'b1};
        do_read(5'd1, 6'd2, 0);
        chk("r1_rows", DW'(rlog.size()), DW'(2));
        chk("r1_row0", rlog[0], DW'(1337));
        chk("r1_row1", rlog[1], DW'(2022));

        // Backpressured read of four rows
        wq = '{DW'(8'hA3), DW'(8'hA4), DW'(8'hA5), DW'(8'hA6)};
        do_write(5'd3, 6'd4, 4);
        rpat = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_read(5'd3, 6'd4, 0);
        chk("r3_rows", DW'(rlog.size()), DW'(4));
        chk("r3_row0", rlog[0], DW'(8'hA3));
        chk("r3_row1", rlog[1], DW'(8'hA4));
        chk("r3_row2", rlog[2], DW'(8'hA5));
        chk("r3_row3", rlog[3], DW'(8'hA6));

        // Address wrap 31 -> 0
        wq = '{DW'(7), DW'(8)};
        do_write(5'd31, 6'd2, 2);
        chk("wrap_addr0", DW'(waddr_log[0]), DW'(31));
        chk("wrap_addr1", DW'(waddr_log[1]), DW'(0));
        rpat = '{1'b1};
        do_read(5'd31, 6'd2, 0);
        chk("wrap_row0", rlog[0], DW'(7));
        chk("wrap_row1", rlog[1], DW'(8));

        // Zero-length command with cmd_valid held into the busy cycle
        waddr_log.delete(); d0 = done_cnt; ov_cnt = 0;
        send_cmd(1'b0, 5'd5, 6'd0, 1);
        repeat (4) begin @(posedge clk); #1; end
        chk("len0_done_count", DW'(done_cnt - d0), DW'(1));
        chk("len0_writes", DW'(waddr_log.size()), DW'(0));
        chk("len0_out_valid", DW'(ov_cnt), DW'(0));

        // Reset during a 3-row read after the first row is delivered
        d0 = done_cnt;
        rpat = '{1'b1};
        do_read(5'd1, 6'd3, 1);
        #2 rst_n = 1'b0;
        #1;
        chk1("abort_out_valid", out_valid, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_cmd_ready", cmd_ready, 1'b1);
        chk1("abort_done", done, 1'b0);
        chk("abort_addr_b", DW'(ram_addr_b), '0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_no_done", DW'(done_cnt - d0), DW'(0));
        do_read(5'd1, 6'd3, 0);
        chk("reread_row0", rlog[0], DW'(1337));
        chk("reread_row1", rlog[1], DW'(2022));
        chk("reread_row2", rlog[2], DW'(8'hA3));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sdpram_burst_ctrl.md
Name: sdpram_burst_ctrl

Overview:
- Burst controller that sequences the 32x256 synchronous dual-port row RAM (sdpram) for the matrix engine.
- Accepts one command at a time: a write burst streams rows in through RAM port A; a read burst streams rows out through RAM port B.
- Sits between the engine's load/store sequencer and the RAM. Valid/ready streams on both sides, plus a done pulse per command.

Parameters:
- DATA_W, 256, row width in bits (matches RAM d/q).
- ADDR_W, 5, RAM address width (depth 2**ADDR_W = 32 rows).
- LEN_W, 6, burst length field width (0..32 rows).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  base row address.
- cmd_len  in  LEN_W  rows to transfer; values above 32 are saturated to 32.
- in_data  in  DATA_W  write-stream row.
- in_valid  in  1  write-stream valid.
- in_ready  out  1  write-stream ready.
- out_data  out  DATA_W  read-stream row.
- out_valid  out  1  read-stream valid.
- out_ready  in  1  read-stream ready.
- busy  out  1  a command is in progress.
- done  out  1  one-cycle pulse when a command completes.
- ram_d_a  out  DATA_W  RAM port A write data.
- ram_addr_a  out  ADDR_W  RAM port A address.
- ram_wen_a  out  1  RAM port A write enable.
- ram_d_b  out  DATA_W  RAM port B write data; constant 0.
- ram_addr_b  out  ADDR_W  RAM port B address.
- ram_wen_b  out  1  RAM port B write enable; constant 0.
- ram_q_b  in  DATA_W  RAM port B read data, registered in the RAM (1-cycle latency).

Behaviour:
- Reset values (asynchronous, rst_n = 0):
  - state = IDLE; all counters = 0; output FIFO empty; in-flight flag = 0.
  - ram_wen_a = 0, ram_addr_a = 0, ram_d_a = 0, ram_addr_b = 0.
  - out_valid = 0, in_ready = 0, busy = 0, done = 0, cmd_ready = 1.
- States:
  - IDLE: cmd_ready = 1. A cmd handshake latches base, saturated length and direction, and moves to WRITE, READ, or FINISH (length 0).
  - WRITE: in_ready = 1 while written < len.
  - READ: issues reads and drains the output FIFO.
  - FINISH: done = 1 for one cycle, then back to IDLE.
  - busy = 1 in every state except IDLE.
- Addressing: row i of a burst goes to (base + i) mod 32. Wrap-around from 31 to 0 is silent.
- Write path:
  - Each in_valid & in_ready beat registers ram_wen_a = 1, ram_addr_a = base + i, ram_d_a = in_data. The RAM commits the row on the following edge.
  - ram_wen_a is 1 for exactly one cycle per beat and 0 otherwise.
  - After the len-th beat, in_ready drops the next cycle and the state goes to FINISH.
  - done is asserted in the cycle where the last ram_wen_a = 1 is presented.
- Read path:
  - ram_addr_b is combinational from the issue counter: base + issued.
  - A read issues when issued < len and (fifo_count + inflight − pop) < 2, where pop = out_valid & out_ready.
  - An issued read sets inflight. In the next cycle ram_q_b is pushed into a 2-entry output FIFO.
  - out_data/out_valid come from the FIFO head. Push and pop in the same cycle are both honoured.
  - With out_ready held at 1, throughput is one row per cycle. First out_valid appears 2 cycles after the cmd handshake.
  - READ moves to FINISH once len rows have been popped.
- out_valid/out_data hold stable under backpressure (out_ready = 0). No RAM read is issued that the FIFO cannot absorb, so data is never dropped.
- cmd_valid outside IDLE is ignored (cmd_ready = 0). In IDLE, a command is accepted the same cycle cmd_valid is high.
- cmd_len = 0: go to FINISH with no RAM access; done pulses the cycle after acceptance.
- Reset asserted mid-burst aborts immediately:
  - FIFO contents discarded; ram_wen_a forced to 0 asynchronously.
  - No done pulse for the aborted command.
  - RAM rows already committed remain.

Test Plan:
- Write burst, base 1, len 2, in_data 1337 then 2022 back-to-back: ram_wen_a high 2 cycles with addr 1/2 and data 1337/2022; done one cycle; busy returns to 0.
- Read burst, base 1, len 2, out_ready = 1, RAM preloaded as above: out_data 1337 then 2022 on consecutive cycles; first out_valid 2 cycles after the cmd handshake; done one cycle after the last pop.
- Read, base 3, len 4, out_ready toggled 1,0,0,1,…: rows delivered in order, none lost or duplicated; ram_addr_b never advances while the FIFO holds 2 entries plus inflight.
- Wrap: write base 31, len 2 (data 7, 8), then read base 31, len 2: write addresses 31, 0; read returns 7, 8.
- cmd_len = 0: no ram_wen_a, no out_valid; done pulses the cycle after acceptance; a cmd_valid held high during busy is not accepted.
- Reset mid-read after 1 of 3 beats: all outputs go to reset values immediately, no done; a subsequent read of the same rows returns the correct data.
